// File: rtl/ula_pkg.sv
// Shared ALU definitions: ALUCon codes and the multiply/divide sequencer state type.
package ula_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_MUL = 4'b0011;
    localparam logic [3:0] ALU_NOR = 4'b0100;
    localparam logic [3:0] ALU_DIV = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/ula_muldiv_step.sv
// One iteration of unsigned shift-add multiply or restoring shift-subtract divide.
module ula_muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    input  logic               is_div,
    output logic [2*WIDTH-1:0] acc_next,
    output logic               q_bit
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    always_comb begin
        sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        rem_sh = acc[2*WIDTH-1:WIDTH-1];
        diff   = rem_sh - {1'b0, operand};
        q_bit  = 1'b0;
        if (is_div) begin
            // A clear borrow bit means the divisor fit; the freed LSB is filled by the caller.
            q_bit    = ~diff[WIDTH];
            acc_next = {(q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], 1'b0};
        end else begin
            acc_next = {sum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/ula_mul_div.sv
// Multi-cycle signed multiply/divide with HI/LO results and start/busy/done handshake.
// state | meaning
// IDLE  | waiting for start with a MUL or DIV code
// RUN   | one iteration per cycle, WIDTH cycles
// DONE  | results valid, done pulses for this cycle
module ula_mul_div
    import ula_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       ALUCon,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    state_t             state;
    logic [CW-1:0]      cnt;
    logic               op_div;
    logic               neg_q;
    logic               neg_r;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;

    logic               is_mul;
    logic               is_div;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] acc_word;
    logic               q_bit;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? -x : x;
    endfunction

    assign is_mul = (ALUCon == ALU_MUL);
    assign is_div = (ALUCon == ALU_DIV);
    assign a_mag  = magnitude(a);
    assign b_mag  = magnitude(b);
    assign busy   = (state != IDLE);

    ula_muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc),
        .operand  (opnd),
        .is_div   (op_div),
        .acc_next (acc_next),
        .q_bit    (q_bit)
    );

    assign acc_word = acc_next | {{(2*WIDTH-1){1'b0}}, q_bit};
    assign prod     = neg_q ? -acc_word : acc_word;
    assign quo      = neg_q ? -acc_word[WIDTH-1:0] : acc_word[WIDTH-1:0];
    assign rem      = neg_r ? -acc_word[2*WIDTH-1:WIDTH] : acc_word[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            done        <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
            op_div      <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            acc         <= '0;
            opnd        <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && (is_mul || is_div)) begin
                        div_by_zero <= 1'b0;
                        op_div      <= is_div;
                        neg_q       <= a[WIDTH-1] ^ b[WIDTH-1];
                        neg_r       <= a[WIDTH-1];
                        cnt         <= CW'(WIDTH - 1);
                        acc         <= {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
                        opnd        <= is_div ? b_mag : a_mag;
                        if (is_div && (b == '0)) begin
                            hi          <= a;
                            lo          <= '1;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            state       <= DONE;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    acc <= acc_word;
                    if (cnt == '0) begin
                        if (op_div) begin
                            hi <= rem;
                            lo <= quo;
                        end else begin
                            hi <= prod[2*WIDTH-1:WIDTH];
                            lo <= prod[WIDTH-1:0];
                        end
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ula_mul_div.sv
// Scoreboard bench for ula_mul_div: expected HI/LO queued at issue, compared on each done pulse.
module tb_ula_mul_div;
    import ula_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  ALUCon;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          done_count = 0;
    int          last_done_cyc = -1;
    logic [31:0] last_hi = '0;
    logic [31:0] last_lo = '0;

    ula_mul_div #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .ALUCon      (ALUCon),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_count++;
            last_done_cyc = cyc;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected: done pulse at cycle %0d with nothing outstanding", cyc);
            end else begin
                mon_e = sb.pop_front();
                last_hi = mon_e.hi;
                last_lo = mon_e.lo;
                if (hi !== mon_e.hi || lo !== mon_e.lo || div_by_zero !== mon_e.dbz || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL result: got hi=%h lo=%h dbz=%b busy=%b, expected hi=%h lo=%h dbz=%b busy=1",
                             hi, lo, div_by_zero, busy, mon_e.hi, mon_e.lo, mon_e.dbz);
                end
            end
        end
    end

    function automatic exp_t model(input bit div, input logic [31:0] x, input logic [31:0] y);
        exp_t   e;
        longint p;
        int     q;
        int     r;
        e.dbz = 1'b0;
        if (!div) begin
            p = longint'($signed(x)) * longint'($signed(y));
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else begin
            q = $signed(x) / $signed(y);
            r = $signed(x) % $signed(y);
            e.hi = r;
            e.lo = q;
        end
        return e;
    endfunction

    task automatic push(input logic [31:0] h, input logic [31:0] l, input logic z);
        exp_t e;
        e.hi = h;
        e.lo = l;
        e.dbz = z;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] aa, input logic [31:0] bb, output int c0);
        @(negedge clk);
        start = 1'b1;
        ALUCon = op;
        a = aa;
        b = bb;
        @(posedge clk);
        #1;
        c0 = cyc;
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        ALUCon = 4'($urandom);
    endtask

    task automatic wait_done(input int prev, input string name);
        int n = 0;
        while (done_count == prev && n < 100) begin
            @(posedge clk);
            #2;
            n++;
        end
        checks++;
        if (done_count == prev) begin
            errors++;
            $display("FAIL %s_timeout: done_count=%0d, required more than %0d within 100 cycles", name, done_count, prev);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b0;
        ALUCon = 4'b0000;
        a = '0;
        b = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0 || hi !== '0 || lo !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b dbz=%b hi=%h lo=%h, required all 0", busy, done, div_by_zero, hi, lo);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    task automatic test_mul;
        int  c0;
        int  prev;
        bit  run_ok = 1'b1;
        push(32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        prev = done_count;
        issue(ALU_MUL, 32'd7, 32'hFFFF_FFFD, c0);
        for (int i = 1; i < 32; i++) begin
            if (busy !== 1'b1 || done !== 1'b0) run_ok = 1'b0;
            @(posedge clk);
            #1;
        end
        if (busy !== 1'b1 || done !== 1'b0) run_ok = 1'b0;
        checks++;
        if (!run_ok) begin
            errors++;
            $display("FAIL mul_run_busy: busy/done wrong during E0..E31, required busy=1 done=0");
        end
        wait_done(prev, "mul_7x_3");
        checks++;
        if (last_done_cyc - c0 != 32) begin
            errors++;
            $display("FAIL mul_done_timing: done at E%0d, required E32", last_done_cyc - c0);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL mul_busy_fall: busy=%b after E33, required 0", busy);
        end
        push(32'h0, 32'h1, 1'b0);
        prev = done_count;
        issue(ALU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, c0);
        wait_done(prev, "mul_m1xm1");
    endtask

    task automatic test_div;
        int c0;
        int prev;
        push(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        prev = done_count;
        issue(ALU_DIV, 32'hFFFF_FFF9, 32'd2, c0);
        wait_done(prev, "div_m7_2");
        push(32'h0, 32'h8000_0000, 1'b0);
        prev = done_count;
        issue(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, c0);
        wait_done(prev, "div_overflow");
        checks++;
        if (last_done_cyc - c0 != 32) begin
            errors++;
            $display("FAIL div_done_timing: done at E%0d, required E32", last_done_cyc - c0);
        end
    endtask

    task automatic test_div_by_zero;
        int c0;
        int prev;
        push(32'd5, 32'hFFFF_FFFF, 1'b1);
        prev = done_count;
        issue(ALU_DIV, 32'd5, 32'd0, c0);
        checks++;
        if (busy !== 1'b1 || done !== 1'b1) begin
            errors++;
            $display("FAIL dbz_e0: busy=%b done=%b after E0, required 1 1", busy, done);
        end
        wait_done(prev, "dbz");
        checks++;
        if (last_done_cyc != c0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL dbz_timing: done at E%0d busy=%b after E1, required E0 and 0", last_done_cyc - c0, busy);
        end
        push(32'h0, 32'd6, 1'b0);
        prev = done_count;
        issue(ALU_MUL, 32'd2, 32'd3, c0);
        wait_done(prev, "mul_after_dbz");
    endtask

    task automatic test_ignored;
        int   c0;
        int   prev;
        int   n;
        exp_t e;
        prev = done_count;
        @(negedge clk);
        start = 1'b1;
        ALUCon = ALU_ADD;
        a = 32'd9;
        b = 32'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done_count != prev || hi !== last_hi || lo !== last_lo) begin
            errors++;
            $display("FAIL ignore_add: busy=%b dones=%0d hi=%h lo=%h, required 0 %0d %h %h",
                     busy, done_count - prev, hi, lo, 0, last_hi, last_lo);
        end

        e = model(1'b0, 32'd11, 32'd13);
        sb.push_back(e);
        prev = done_count;
        issue(ALU_MUL, 32'd11, 32'd13, c0);
        repeat (5) @(negedge clk);
        start = 1'b1;
        ALUCon = ALU_DIV;
        a = 32'd100;
        b = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(prev, "start_in_run");
        repeat (40) @(posedge clk);
        #1;
        checks++;
        if (done_count != prev + 1 || busy !== 1'b0 || lo !== 32'd143) begin
            errors++;
            $display("FAIL ignore_run: dones=%0d busy=%b lo=%h, required 1 0 %h", done_count - prev, busy, lo, 32'd143);
        end

        push(32'h0, 32'd81, 1'b0);
        prev = done_count;
        issue(ALU_MUL, 32'd9, 32'd9, c0);
        n = 0;
        @(negedge clk);
        while (done !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL done_wait_timeout: done=%b, required 1 within 60 cycles", done);
        end
        start = 1'b1;
        ALUCon = ALU_MUL;
        a = 32'd1000;
        b = 32'd1000;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL ignore_done: busy=%b after start in DONE, required 0", busy);
        end
        e = model(1'b0, 32'hFFFF_FFFA, 32'd7);
        sb.push_back(e);
        @(negedge clk);
        start = 1'b1;
        ALUCon = ALU_MUL;
        a = 32'hFFFF_FFFA;
        b = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL accept_after_done: busy=%b, required 1", busy);
        end
        wait_done(prev + 1, "accept_after_done");
        repeat (40) @(posedge clk);
        #1;
        checks++;
        if (done_count != prev + 2 || lo !== 32'hFFFF_FFD6) begin
            errors++;
            $display("FAIL done_count_after_done: dones=%0d lo=%h, required 2 %h", done_count - prev, lo, 32'hFFFF_FFD6);
        end
    endtask

    task automatic test_random;
        int          c0;
        int          prev;
        bit          div;
        logic [31:0] x;
        logic [31:0] y;
        for (int i = 0; i < 8; i++) begin
            div = 1'($urandom);
            x = $urandom;
            y = (i < 4) ? 32'($urandom_range(1, 40)) - 32'd20 : $urandom;
            if (y == 32'd0) y = 32'd3;
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) y = 32'd5;
            sb.push_back(model(div, x, y));
            prev = done_count;
            issue(div ? ALU_DIV : ALU_MUL, x, y, c0);
            wait_done(prev, "random");
        end
    endtask

    task automatic test_reset_mid;
        int c0;
        int prev;
        prev = done_count;
        issue(ALU_DIV, 32'd1000, 32'd7, c0);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        last_hi = '0;
        last_lo = '0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_run: busy=%b done=%b hi=%h lo=%h dbz=%b, required all 0", busy, done, hi, lo, div_by_zero);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        checks++;
        if (done_count != prev || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_abandon: dones=%0d busy=%b, required 0 0", done_count - prev, busy);
        end
        push(32'h0, 32'd20, 1'b0);
        issue(ALU_MUL, 32'd4, 32'd5, c0);
        wait_done(prev, "mul_after_reset");
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_div_by_zero();
        test_ignored();
        test_random();
        test_reset_mid();
        repeat (3) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d results outstanding, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
